// File: rtl/rx_sys.sv
// rx_sys: receive-side scoreboard for the fp16 multiply-add datapath.
// Pops in-order expectations on each out_valid beat and compares them.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   exp_valid, exp_data   expected-result push (from tx_sys)
//   out_valid, fp16_d     DUT result beat
//   pass_cnt, fail_cnt    checked-result counters (saturating)
//   unexp_cnt             beats with no pending expectation
//   mm_got, mm_exp        first mismatch capture, held while mm_valid
//   overflow, timeout     sticky error flags
//   done, state           completion flag, 0=IDLE 1=RUN 2=DONE 3=TOUT
module rx_sys #(
  parameter int DEPTH   = 8,
  parameter int NUM_TXN = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16,
  parameter int ZERO_EQ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exp_valid,
  input  logic [15:0]      exp_data,
  input  logic             out_valid,
  input  logic [15:0]      fp16_d,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] unexp_cnt,
  output logic [15:0]      mm_got,
  output logic [15:0]      mm_exp,
  output logic             mm_valid,
  output logic             overflow,
  output logic             timeout,
  output logic             done,
  output logic [1:0]       state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } st_e;

  st_e st_q, st_d;

  logic [15:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [TW-1:0] stall_q;

  logic          empty, full, active;
  logic          pop, push, unexp, ovf_set;
  logic          stall_inc, stall_hit, last_chk;
  logic          match;
  logic [15:0]   head;
  logic [CNT_W:0] chk_sum;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NaNs match regardless of payload/sign; infinities only bit-exactly.
  function automatic logic fp_match(
    input logic [15:0] e,
    input logic [15:0] g
  );
    logic e_nan, g_nan, e_z, g_z;
    e_nan = (&e[14:10]) && (|e[9:0]);
    g_nan = (&g[14:10]) && (|g[9:0]);
    e_z   = (e[14:0] == 15'd0);
    g_z   = (g[14:0] == 15'd0);
    return (e == g) || (e_nan && g_nan) ||
           ((ZERO_EQ != 0) && e_z && g_z);
  endfunction

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign active = (st_q == IDLE) || (st_q == RUN);
  assign head   = mem[rd_ptr[AW-1:0]];
  assign match  = fp_match(head, fp16_d);

  // No bypass: a push into an empty FIFO is not visible to a same-cycle beat.
  assign pop     = out_valid && (st_q == RUN) && !empty;
  assign unexp   = out_valid && !pop;
  assign push    = exp_valid && active && (!full || pop);
  assign ovf_set = exp_valid && active && full && !pop;

  assign chk_sum  = {1'b0, pass_cnt} + {1'b0, fail_cnt} + (CNT_W+1)'(1);
  assign last_chk = pop && (chk_sum == (CNT_W+1)'(NUM_TXN));

  assign stall_inc = (st_q == RUN) && !empty && !out_valid;
  assign stall_hit = stall_inc && (stall_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      unexp_cnt <= '0;
      mm_got    <= '0;
      mm_exp    <= '0;
      mm_valid  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (unexp) unexp_cnt <= sat_inc(unexp_cnt);
      if (ovf_set) overflow <= 1'b1;
      if (pop && match) pass_cnt <= sat_inc(pass_cnt);
      if (pop && !match) begin
        fail_cnt <= sat_inc(fail_cnt);
        if (!mm_valid) begin
          mm_got   <= fp16_d;
          mm_exp   <= head;
          mm_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (stall_inc) begin
      stall_q <= stall_q + TW'(1);
    end else begin
      stall_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // A final check needs out_valid, which also clears the stall timer,
  // but DONE is still tested first so it always wins.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (exp_valid) st_d = RUN;
      RUN: begin
        if (last_chk)       st_d = DONE;
        else if (stall_hit) st_d = TOUT;
      end
      default: st_d = st_q;
    endcase
  end

  always_comb begin
    done    = (st_q == DONE);
    timeout = (st_q == TOUT);
    state   = st_q;
  end

endmodule

// File: tb/tb_rx_sys.sv
// tb_rx_sys: directed plus randomized checks of rx_sys against
// a queue-based scoreboard model.
module tb_rx_sys;

  localparam int DEPTH   = 8;
  localparam int NUM_TXN = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;
  localparam int ZERO_EQ = 1;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             exp_valid = 1'b0;
  logic [15:0]      exp_data = '0;
  logic             out_valid = 1'b0;
  logic [15:0]      fp16_d = '0;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, unexp_cnt;
  logic [15:0]      mm_got, mm_exp;
  logic             mm_valid, overflow, timeout, done;
  logic [1:0]       state;

  rx_sys #(
    .DEPTH(DEPTH), .NUM_TXN(NUM_TXN), .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W), .ZERO_EQ(ZERO_EQ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .out_valid(out_valid), .fp16_d(fp16_d),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .unexp_cnt(unexp_cnt),
    .mm_got(mm_got), .mm_exp(mm_exp), .mm_valid(mm_valid),
    .overflow(overflow), .timeout(timeout),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t",
               nm, got, want, $time);
    end
  endtask

  // ---- behavioural model ----
  logic [15:0] q[$];
  int          m_pass, m_fail, m_unexp, m_stall, m_st;
  logic [15:0] m_got, m_exp;
  bit          m_mmv, m_ovf;

  function automatic bit ref_match(input logic [15:0] e,
                                   input logic [15:0] g);
    bit en, gn, ez, gz;
    en = (e & 16'h7FFF) > 16'h7C00;
    gn = (g & 16'h7FFF) > 16'h7C00;
    ez = (e & 16'h7FFF) == 16'h0000;
    gz = (g & 16'h7FFF) == 16'h0000;
    return (e == g) || (en && gn) || (ZERO_EQ != 0 && ez && gz);
  endfunction

  function automatic int sat1(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pass <= 0; m_fail <= 0; m_unexp <= 0;
      m_stall <= 0; m_st <= 0;
      m_got <= '0; m_exp <= '0;
      m_mmv <= 0; m_ovf <= 0;
    end else begin
      int pre, np, nf, st, stl;
      bit popped;
      logic [15:0] h;
      pre = q.size();
      popped = 0;
      np = m_pass; nf = m_fail; st = m_st; stl = m_stall;
      if (out_valid) begin
        if (m_st == 1 && pre > 0) begin
          h = q.pop_front();
          popped = 1;
          if (ref_match(h, fp16_d)) np = sat1(m_pass);
          else begin
            nf = sat1(m_fail);
            if (!m_mmv) begin
              m_mmv <= 1; m_got <= fp16_d; m_exp <= h;
            end
          end
        end else m_unexp <= sat1(m_unexp);
      end
      if (exp_valid && m_st < 2) begin
        if (pre < DEPTH || popped) q.push_back(exp_data);
        else m_ovf <= 1;
      end
      if (m_st == 0) begin
        if (exp_valid) st = 1;
      end else if (m_st == 1) begin
        if (popped && np + nf == NUM_TXN) st = 2;
        else if (pre > 0 && !out_valid) begin
          stl = m_stall + 1;
          if (stl >= TIMEOUT) st = 3;
        end else stl = 0;
      end
      m_pass <= np; m_fail <= nf; m_st <= st; m_stall <= stl;
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
      chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
      chk("unexp_cnt", 32'(unexp_cnt), 32'(m_unexp));
      chk("mm_valid", 32'(mm_valid), 32'(m_mmv));
      chk("mm_got", 32'(mm_got), 32'(m_got));
      chk("mm_exp", 32'(mm_exp), 32'(m_exp));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("timeout", 32'(timeout), 32'(m_st == 3));
      chk("done", 32'(done), 32'(m_st == 2));
      chk("state", 32'(state), 32'(m_st));
    end
  end

  // ---- stimulus helpers ----
  task automatic step(input bit ev, input logic [15:0] ed,
                      input bit ov, input logic [15:0] od);
    exp_valid = ev; exp_data = ed;
    out_valid = ov; fp16_d = od;
    @(negedge clk);
    exp_valid = 0; out_valid = 0;
  endtask

  task automatic do_reset();
    exp_valid = 0; out_valid = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7C00;
      3: return 16'hFC00;
      4: return 16'h7C00 | (r & 16'h83FF) | 16'h0001;
      5: return 16'hFE01;
      default: return r;
    endcase
  endfunction

  initial begin
    do_reset();
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_mmv", 32'(mm_valid), 0);

    // 1: single match
    step(1, 16'hDD88, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'hDD88);
    chk("t1_pass", 32'(pass_cnt), 1);
    chk("t1_fail", 32'(fail_cnt), 0);
    chk("t1_state", 32'(state), 1);
    chk("t1_model", 32'(m_pass), 1);

    // 2: first mismatch capture
    do_reset();
    step(1, 16'hDD88, 0, 0);
    step(1, 16'h3C00, 0, 0);
    step(0, 0, 1, 16'hDD89);
    step(0, 0, 1, 16'h4000);
    chk("t2_fail", 32'(fail_cnt), 2);
    chk("t2_got", 32'(mm_got), 32'h0000DD89);
    chk("t2_exp", 32'(mm_exp), 32'h0000DD88);
    chk("t2_mmv", 32'(mm_valid), 1);

    // 3: NaN / signed zero / infinity
    do_reset();
    step(1, 16'h7E00, 0, 0);
    step(1, 16'h0000, 0, 0);
    step(1, 16'h7C00, 0, 0);
    step(0, 0, 1, 16'hFE01);
    step(0, 0, 1, 16'h8000);
    chk("t3_pass", 32'(pass_cnt), 2);
    step(0, 0, 1, 16'hFC00);
    chk("t3_fail", 32'(fail_cnt), 1);
    chk("t3_got", 32'(mm_got), 32'h0000FC00);

    // 4: fill, paired push/pop at full, overflow, drain to DONE
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'h1000 + 16'(i), 0, 0);
    chk("t4_noovf", 32'(overflow), 0);
    for (int k = 0; k < 8; k++)
      step(1, 16'h2000 + 16'(k), 1, 16'h1000 + 16'(k));
    chk("t4_pair_ovf", 32'(overflow), 0);
    chk("t4_pair_pass", 32'(pass_cnt), 8);
    step(1, 16'h3333, 0, 0);
    chk("t4_ovf", 32'(overflow), 1);
    for (int k = 0; k < 8; k++) step(0, 0, 1, 16'h2000 + 16'(k));
    chk("t4_pass", 32'(pass_cnt), 16);
    chk("t4_done", 32'(done), 1);
    chk("t4_state", 32'(state), 2);
    chk("t4_unexp", 32'(unexp_cnt), 0);

    // 5: unexpected in IDLE, then timeout
    do_reset();
    step(0, 0, 1, 16'h1234);
    chk("t5_unexp1", 32'(unexp_cnt), 1);
    step(1, 16'hABCD, 0, 0);
    repeat (TIMEOUT - 1) step(0, 0, 0, 0);
    chk("t5_run", 32'(state), 1);
    step(0, 0, 0, 0);
    chk("t5_tout", 32'(timeout), 1);
    chk("t5_state", 32'(state), 3);
    step(0, 0, 1, 16'hABCD);
    chk("t5_unexp2", 32'(unexp_cnt), 2);

    // 6: asynchronous reset mid-test
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 16'hA000 + 16'(i), 0, 0);
    step(0, 0, 1, 16'hA000);
    step(0, 0, 1, 16'hA001);
    chk("t6_pass", 32'(pass_cnt), 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_pass", 32'(pass_cnt), 0);
    chk("t6_rst_unexp", 32'(unexp_cnt), 0);
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_done", 32'(done), 0);
    #1 rst_n = 1;
    @(negedge clk);
    step(1, 16'h5555, 0, 0);
    step(0, 0, 1, 16'h5555);
    chk("t6_empty_pass", 32'(pass_cnt), 1);
    chk("t6_empty_fail", 32'(fail_cnt), 0);

    // randomized rounds
    begin
      int pov[6] = '{50, 70, 30, 0, 90, 40};
      for (int r = 0; r < 6; r++) begin
        int pev;
        do_reset();
        pev = $urandom_range(30, 80);
        for (int c = 0; c < 250; c++) begin
          bit ev, ov;
          logic [15:0] ed, od;
          ev = ($urandom_range(99) < pev);
          ed = pick();
          ov = ($urandom_range(99) < pov[r]);
          od = pick();
          if (q.size() > 0) begin
            case ($urandom_range(3))
              0, 1: od = q[0];
              2: od = q[0] ^ (16'h1 << $urandom_range(15));
              default: ;
            endcase
          end
          step(ev, ed, ov, od);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
